// File: rtl/down_timer_if.sv
// ---------------------------------------------------------------------------
// down_timer_if : control/status bundle for down_timer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface down_timer_if #(
  parameter int BITS = 4
);
  logic            start;
  logic [BITS-1:0] load_val;
  logic            stop;
  logic            en;
  logic            auto_reload;
  logic [BITS-1:0] Q;
  logic            tc;
  logic            busy;

  modport master (
    output start, load_val, stop, en, auto_reload,
    input  Q, tc, busy
  );

  modport slave (
    input  start, load_val, stop, en, auto_reload,
    output Q, tc, busy
  );
endinterface

`default_nettype wire

// File: rtl/down_timer.sv
// ---------------------------------------------------------------------------
// down_timer : loadable down counter with terminal-count pulse and optional
//              auto-reload. Define DOWN_TIMER_PRESCALE_EN to add a prescaler.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module down_timer #(
  parameter int BITS     = 4,
  parameter int PRESCALE = 4
) (
  input  wire          clk,
  input  wire          reset_n,
  down_timer_if.slave  bus
);

  generate
    if (BITS < 2) begin : g_bits_check
      $error("down_timer: BITS must be >= 2");
    end
    if (PRESCALE < 1) begin : g_prescale_check
      $error("down_timer: PRESCALE must be >= 1");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [BITS-1:0] ONE = BITS'(1);

  state_t          state, state_next;
  logic [BITS-1:0] count, count_next;
  logic [BITS-1:0] reload, reload_next;
  logic            term, term_next;
  logic            due;
  logic            pre_clear;

`ifdef DOWN_TIMER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;

  assign due = (pre_cnt == PRE_LAST);

  // Advances only on enabled RUN cycles; start/stop restart the division.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
    end else if (pre_clear) begin
      pre_cnt <= '0;
    end else if (state == RUN && bus.en) begin
      pre_cnt <= due ? '0 : pre_cnt + PW'(1);
    end
  end
`else
  assign due = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      term   <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      reload <= reload_next;
      term   <= term_next;
    end
  end

  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = reload;
    term_next   = 1'b0;
    pre_clear   = 1'b0;

    if (bus.start) begin
      pre_clear = 1'b1;
      if (bus.load_val != '0) begin
        count_next  = bus.load_val;
        reload_next = bus.load_val;
        state_next  = RUN;
      end else begin
        count_next = '0;
        term_next  = 1'b1;
        state_next = IDLE;
      end
    end else if (state == RUN) begin
      if (bus.stop) begin
        pre_clear  = 1'b1;
        state_next = IDLE;
      end else if (bus.en && due) begin
        if (count > ONE) begin
          count_next = count - ONE;
        end else begin
          // Expiry: reload skips the zero state so the period is load_val.
          term_next = 1'b1;
          if (bus.auto_reload) begin
            count_next = reload;
          end else begin
            count_next = '0;
            state_next = IDLE;
          end
        end
      end
    end
  end

  assign bus.Q    = count;
  assign bus.tc   = term;
  assign bus.busy = (state == RUN);

endmodule

`default_nettype wire

// File: doc/down_timer.md
DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 Parameter BITS, default 4, counter width; SHALL be >= 2.
REQ-002 Parameter PRESCALE, default 4, enabled cycles per decrement when DOWN_TIMER_PRESCALE_EN is defined; SHALL be >= 1; ignored otherwise.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle request to load load_val and begin counting.
REQ-006 load_val  input  BITS  start value, sampled only when start=1.
REQ-007 stop  input  1  abort the current count.
REQ-008 en  input  1  count enable; decrement allowed only when 1.
REQ-009 auto_reload  input  1  reload the stored start value on expiry instead of halting.
REQ-010 Q  output  BITS  registered current count.
REQ-011 tc  output  1  registered terminal-count pulse, one cycle wide.
REQ-012 busy  output  1  registered; 1 while in state RUN.

Function
REQ-013 FSM states IDLE and RUN; busy SHALL equal (state==RUN).
REQ-014 start=1 with load_val!=0, in any state: next edge Q=load_val, reload register=load_val, state=RUN, tc=0.
REQ-015 start=1 with load_val==0: next edge Q=0, tc=1 for one cycle, state=IDLE.
REQ-016 start SHALL take priority over stop, en and expiry in the same cycle.
REQ-017 stop=1 with start=0 in RUN: next edge state=IDLE, Q holds its value, tc=0.
REQ-018 RUN, en=1, decrement due, Q>1: Q<=Q-1.
REQ-019 RUN, en=1, decrement due, Q==1, auto_reload=0: Q<=0, tc<=1, state<=IDLE.
REQ-020 RUN, en=1, decrement due, Q==1, auto_reload=1: Q<=reload register, tc<=1, state stays RUN; Q SHALL NOT show 0, giving a period of load_val decrements.
REQ-021 RUN with en=0: Q and the prescale count hold, tc=0.
REQ-022 IDLE without start: Q holds, tc=0; en and auto_reload have no effect.
REQ-023 Q SHALL never underflow or wrap below 0; arithmetic is unsigned BITS-wide.
REQ-024 tc SHALL be 0 in every cycle not defined above as a tc pulse.

Reset
REQ-025 reset_n=0 SHALL immediately force: state=IDLE, Q=0, tc=0, busy=0, reload register=0, prescale count=0.
REQ-026 Reset asserted mid-count SHALL abort with no tc pulse; after deassertion the block waits in IDLE for start.

Configuration
REQ-027 Macro DOWN_TIMER_PRESCALE_EN, when defined: a prescale counter of width max(1,$clog2(PRESCALE)) advances on each RUN cycle with en=1; a decrement is due only when it equals PRESCALE-1, at which point it wraps to 0; start and stop clear it to 0.
REQ-028 Macro undefined: no prescale logic is built, and a decrement is due on every RUN cycle with en=1.

Verification (BITS=4, macro undefined unless stated)
REQ-029 Reset, then start=1 with load_val=3, en=1 held -> Q sequence after start edge 3,2,1,0; tc=1 only in the cycle Q first reads 0; busy falls in that same cycle.
REQ-030 auto_reload=1, start with load_val=2, en=1 -> Q 2,1,2,1,...; tc pulses in each cycle Q returns to 2 (period 2); busy stays 1.
REQ-031 start with load_val=5, en toggling 1,0,1,0 -> Q 5,4,4,3,3; stop asserted at Q=3 -> Q holds 3, busy=0, no tc.
REQ-032 start with load_val=0 -> Q=0, one-cycle tc, busy stays 0; start with 9 while Q=4 in RUN, together with stop=1 -> Q=9, RUN.
REQ-033 reset_n pulsed low asynchronously at Q=6 -> Q=0, busy=0, tc=0 immediately, with no tc pulse afterward.
REQ-034 Macro defined, PRESCALE=3, start with load_val=2, en=1 -> Q holds 2 for 3 cycles, holds 1 for 3 cycles, then reads 0 with tc=1.
